// File: rtl/us_fault_monitor_if.sv
// Byte-stream handshake from the fault monitor to the bluetooth UART transmitter.
// A byte moves on every clock edge where tx_valid && tx_ready.
interface us_fault_monitor_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/us_fault_monitor.sv
// Ultrasonic fault monitor: periodic trigger, echo-width measurement, N-reading fault confirmation,
// RGB status LEDs and an ASCII fault report. Define DIST_REPORT_EN to append the echo distance byte.
module us_fault_monitor #(
  parameter int         TRIG_CYCLES   = 500,
  parameter int         PERIOD_CYCLES = 3000000,
  parameter int         ECHO_TIMEOUT  = 1500000,
  parameter int         CNT_W         = 22,
  parameter int         NEAR_THRESH   = 16500,
  parameter int         CONFIRM       = 2,
  parameter int         NUM_LEDS      = 3,
  parameter logic [7:0] UNIT_ID       = 8'h31
) (
  input  logic                clk_50M,
  input  logic                rst,
  input  logic                us_echo,
  input  logic                node_flag,
  output logic                us_trig,
  output logic [CNT_W-1:0]    echo_width,
  output logic                echo_valid,
  output logic                fault_active,
  output logic [3:0]          fault_count,
  output logic [NUM_LEDS-1:0] led_r,
  output logic [NUM_LEDS-1:0] led_g,
  output logic [NUM_LEDS-1:0] led_b,
  us_fault_monitor_if.master  tx
);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_W      = CNT_W'(ECHO_TIMEOUT);
  localparam int               CW        = $clog2(CONFIRM + 1);
`ifdef DIST_REPORT_EN
  localparam logic [3:0]       MSG_LAST  = 4'd9;
`else
  localparam logic [3:0]       MSG_LAST  = 4'd7;
`endif

  // ---------------- sensor sequencer ----------------
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_HOLD} sens_e;
  sens_e             s_q, s_d;
  logic [CNT_W-1:0]  per_cnt, st_cnt, width_q, width_d, pub_w;
  logic              pub;

  always_comb begin
    s_d     = s_q;
    width_d = width_q;
    pub     = 1'b0;
    pub_w   = '0;
    case (s_q)
      S_IDLE: s_d = S_TRIG;
      S_TRIG: if (st_cnt == TRIG_LAST) s_d = S_WAIT;
      S_WAIT:
        if (us_echo) begin
          s_d     = S_MEAS;
          width_d = CNT_W'(1);
        end else if (st_cnt == TO_LAST) begin
          pub = 1'b1;
          s_d = S_HOLD;
        end
      S_MEAS:
        if (!us_echo) begin
          pub   = 1'b1;
          pub_w = width_q;
          s_d   = S_HOLD;
        end else begin
          width_d = width_q + CNT_W'(1);
          if (width_d == TO_W) begin
            pub   = 1'b1;
            pub_w = TO_W;
            s_d   = S_HOLD;
          end
        end
      S_HOLD: if (per_cnt == PER_LAST) s_d = S_TRIG;
      default: s_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      s_q        <= S_IDLE;
      per_cnt    <= '0;
      st_cnt     <= '0;
      width_q    <= '0;
      echo_width <= '0;
      echo_valid <= 1'b0;
    end else begin
      s_q        <= s_d;
      // period is measured from the first trigger cycle
      per_cnt    <= (s_d == S_TRIG && s_q != S_TRIG) ? '0 : per_cnt + CNT_W'(1);
      st_cnt     <= (s_d != s_q) ? '0 : st_cnt + CNT_W'(1);
      width_q    <= width_d;
      echo_valid <= pub;
      if (pub) echo_width <= pub_w;
    end
  end

  assign us_trig = (s_q == S_TRIG);

  // ---------------- fault detector ----------------
  typedef enum logic {D_CLEAR, D_FAULT} det_e;
  det_e          d_q, d_d;
  logic [CW-1:0] near_q, near_d, far_q, far_d;
  logic          is_near, enter;
  logic [3:0]    next_cnt;
  logic          req;
  logic [7:0]    req_cnt;

  assign is_near  = (echo_width != '0) && (echo_width < CNT_W'(NEAR_THRESH));
  assign next_cnt = (fault_count == 4'd9) ? 4'd9 : fault_count + 4'd1;

  always_comb begin
    d_d    = d_q;
    near_d = near_q;
    far_d  = far_q;
    enter  = 1'b0;
    if (echo_valid) begin
      case (d_q)
        D_CLEAR:
          if (!is_near) near_d = '0;
          else if (near_q == CW'(CONFIRM - 1)) begin
            near_d = '0;
            far_d  = '0;
            enter  = 1'b1;
            d_d    = D_FAULT;
          end else near_d = near_q + CW'(1);
        default:
          if (is_near) far_d = '0;
          else if (far_q == CW'(CONFIRM - 1)) begin
            far_d = '0;
            d_d   = D_CLEAR;
          end else far_d = far_q + CW'(1);
      endcase
    end
  end

`ifdef DIST_REPORT_EN
  logic [CNT_W-1:0] dist_sh;
  logic [7:0]       req_dist;
  assign dist_sh = echo_width >> 8;
`endif

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      d_q         <= D_CLEAR;
      near_q      <= '0;
      far_q       <= '0;
      fault_count <= 4'd0;
      req         <= 1'b0;
      req_cnt     <= 8'h00;
      led_r       <= '0;
      led_g       <= '0;
      led_b       <= '0;
`ifdef DIST_REPORT_EN
      req_dist    <= 8'h00;
`endif
    end else begin
      d_q    <= d_d;
      near_q <= near_d;
      far_q  <= far_d;
      req    <= enter;
      if (enter) begin
        fault_count <= next_cnt;
        req_cnt     <= 8'h30 + {4'h0, next_cnt};
`ifdef DIST_REPORT_EN
        req_dist    <= (dist_sh > CNT_W'(255)) ? 8'hFF : dist_sh[7:0];
`endif
      end
      // node_flag wins over a fault entry in the same cycle
      if (node_flag) begin
        led_r <= '0;
        led_g <= '0;
        led_b <= '0;
      end else if (enter) begin
        led_r <= '0;
        led_g <= '0;
        led_b <= '1;
      end
    end
  end

  assign fault_active = (d_q == D_FAULT);

  // ---------------- report streamer ----------------
  typedef enum logic {T_IDLE, T_SEND} tx_e;
  tx_e        t_q, t_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cur_q, cur_d, pcnt_q, pcnt_d;
  logic       pend_q, pend_d, acc;
`ifdef DIST_REPORT_EN
  logic [7:0] cdist_q, cdist_d, pdist_q, pdist_d;

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
`endif

  assign acc = tx.tx_valid && tx.tx_ready;

  always_comb begin
    t_d    = t_q;
    idx_d  = idx_q;
    cur_d  = cur_q;
    pend_d = pend_q;
    pcnt_d = pcnt_q;
`ifdef DIST_REPORT_EN
    cdist_d = cdist_q;
    pdist_d = pdist_q;
`endif
    case (t_q)
      T_IDLE:
        if (req) begin
          t_d   = T_SEND;
          idx_d = 4'd0;
          cur_d = req_cnt;
`ifdef DIST_REPORT_EN
          cdist_d = req_dist;
`endif
        end
      default: begin
        if (acc) idx_d = idx_q + 4'd1;
        if (acc && idx_q == MSG_LAST) begin
          // last byte leaves: chain straight into the pending (or a just-arrived) report
          idx_d = 4'd0;
          if (pend_q) begin
            cur_d  = pcnt_q;
            pend_d = req;
            if (req) pcnt_d = req_cnt;
`ifdef DIST_REPORT_EN
            cdist_d = pdist_q;
            if (req) pdist_d = req_dist;
`endif
          end else if (req) begin
            cur_d = req_cnt;
`ifdef DIST_REPORT_EN
            cdist_d = req_dist;
`endif
          end else t_d = T_IDLE;
        end else if (req) begin
          pend_d = 1'b1;
          pcnt_d = req_cnt;
`ifdef DIST_REPORT_EN
          pdist_d = req_dist;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      t_q    <= T_IDLE;
      idx_q  <= 4'd0;
      cur_q  <= 8'h00;
      pend_q <= 1'b0;
      pcnt_q <= 8'h00;
`ifdef DIST_REPORT_EN
      cdist_q <= 8'h00;
      pdist_q <= 8'h00;
`endif
    end else begin
      t_q    <= t_d;
      idx_q  <= idx_d;
      cur_q  <= cur_d;
      pend_q <= pend_d;
      pcnt_q <= pcnt_d;
`ifdef DIST_REPORT_EN
      cdist_q <= cdist_d;
      pdist_q <= pdist_d;
`endif
    end
  end

  assign tx.tx_valid = (t_q == T_SEND);

  always_comb begin
    tx.tx_data = 8'h23;
    case (idx_q)
      4'd0: tx.tx_data = 8'h46;
      4'd1: tx.tx_data = 8'h49;
      4'd2: tx.tx_data = 8'h4D;
      4'd3: tx.tx_data = 8'h2D;
      4'd4: tx.tx_data = UNIT_ID;
      4'd5: tx.tx_data = cur_q;
      4'd6: tx.tx_data = 8'h2D;
`ifdef DIST_REPORT_EN
      4'd7: tx.tx_data = hex_ch(cdist_q[7:4]);
      4'd8: tx.tx_data = hex_ch(cdist_q[3:0]);
`endif
      default: tx.tx_data = 8'h23;
    endcase
  end
endmodule

// File: tb/tb_us_fault_monitor.sv
// Directed bench for us_fault_monitor with shortened timing parameters; report bytes are
// collected by a ready-driving monitor and compared against hand-built expected messages.
module tb_us_fault_monitor;
  localparam int TRIG = 10, PER = 1100, TO = 1000, NT = 400, CW = 22, NL = 3;
`ifdef DIST_REPORT_EN
  localparam int MLEN = 10;
`else
  localparam int MLEN = 8;
`endif

  logic          clk_50M = 1'b0, rst = 1'b1, us_echo = 1'b0, node_flag = 1'b0;
  logic          us_trig, echo_valid, fault_active;
  logic [CW-1:0] echo_width;
  logic [3:0]    fault_count;
  logic [NL-1:0] led_r, led_g, led_b;

  us_fault_monitor_if tx ();

  us_fault_monitor #(
    .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .ECHO_TIMEOUT(TO), .CNT_W(CW),
    .NEAR_THRESH(NT), .CONFIRM(2), .NUM_LEDS(NL), .UNIT_ID(8'h31)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .us_echo(us_echo), .node_flag(node_flag),
    .us_trig(us_trig), .echo_width(echo_width), .echo_valid(echo_valid),
    .fault_active(fault_active), .fault_count(fault_count),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .tx(tx)
  );

  always #10 clk_50M = ~clk_50M;

  int         checks = 0, failures = 0, cyc = 0;
  int         rdy_mode = 0, rdy_ph = 0;   // 0: always ready, 1: ready 1 of 3, 2: stalled
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk_50M) cyc <= cyc + 1;

  // drives tx_ready just after each edge and records the byte that the next edge accepts
  always @(posedge clk_50M) begin
    logic r;
    #1;
    if (prev_stall && !rst) begin
      checks++;
      if (tx.tx_valid !== 1'b1 || tx.tx_data !== prev_data) begin
        failures++;
        $display("FAIL stall_hold got valid=%0b data=%0h exp valid=1 data=%0h", tx.tx_valid, tx.tx_data, prev_data);
      end
    end
    case (rdy_mode)
      0:       r = 1'b1;
      1:       r = (rdy_ph == 0);
      default: r = 1'b0;
    endcase
    rdy_ph      = (rdy_ph + 1) % 3;
    tx.tx_ready = r;
    if (tx.tx_valid && r) rx.push_back(tx.tx_data);
    prev_stall = tx.tx_valid && !r && !rst;
    prev_data  = tx.tx_data;
  end

  function automatic logic [7:0] hexch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  task automatic push_msg(input logic [7:0] cnt_ch, input logic [7:0] dv);
    exp_q.push_back(8'h46); exp_q.push_back(8'h49); exp_q.push_back(8'h4D);
    exp_q.push_back(8'h2D); exp_q.push_back(8'h31); exp_q.push_back(cnt_ch);
    exp_q.push_back(8'h2D);
`ifdef DIST_REPORT_EN
    exp_q.push_back(hexch(dv[7:4])); exp_q.push_back(hexch(dv[3:0]));
`endif
    exp_q.push_back(8'h23);
  endtask

  task automatic wait_trig_fall(output bit ok);
    int n = 0;
    while (!us_trig && n < 3 * PER) begin @(negedge clk_50M); n++; end
    while (us_trig && n < 3 * PER) begin @(negedge clk_50M); n++; end
    ok = (n < 3 * PER);
  endtask

  task automatic wait_rx(input int cnt, input int maxc, output bit ok);
    int n = 0;
    while (rx.size() < cnt && n < maxc) begin @(negedge clk_50M); n++; end
    ok = (rx.size() >= cnt);
  endtask

  // echo high for w cycles starting in the first cycle after the trigger
  task automatic do_reading(input int w, input int expw);
    bit ok, seen = 0;
    int n = 0;
    logic [CW-1:0] got = '0;
    wait_trig_fall(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL trig_wait got=timeout exp=trigger"); end
    us_echo = 1'b1;
    for (int i = 0; i < w; i++) begin
      @(negedge clk_50M);
      if (echo_valid && !seen) begin seen = 1; got = echo_width; end
    end
    us_echo = 1'b0;
    while (!seen && n < 2 * TO) begin
      @(negedge clk_50M); n++;
      if (echo_valid) begin seen = 1; got = echo_width; end
    end
    checks++;
    if (!seen || got !== CW'(expw)) begin
      failures++; $display("FAIL echo_width got=%0d seen=%0b exp=%0d", got, seen, expw);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_50M);
    checks++; if (us_trig !== 1'b0) begin failures++; $display("FAIL rst_trig got=%0b exp=0", us_trig); end
    checks++; if (echo_valid !== 1'b0) begin failures++; $display("FAIL rst_echo_valid got=%0b exp=0", echo_valid); end
    checks++; if (echo_width !== '0) begin failures++; $display("FAIL rst_echo_width got=%0d exp=0", echo_width); end
    checks++; if (fault_active !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0b exp=0", fault_active); end
    checks++; if (fault_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fault_count); end
    checks++; if ({led_r, led_g, led_b} !== '0) begin failures++; $display("FAIL rst_leds got=%0h exp=0", {led_r, led_g, led_b}); end
    checks++; if (tx.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%0b exp=0", tx.tx_valid); end
  endtask

  task automatic test_idle_timeout;
    int t0, t1, t2, n = 0;
    bit any_tx = 0, ev_seen = 0;
    rst = 1'b0;
    while (!us_trig && n < 100) begin @(negedge clk_50M); n++; end
    t0 = cyc;
    while (us_trig && n < 3 * PER) begin @(negedge clk_50M); n++; end
    checks++; if (cyc - t0 != TRIG) begin failures++; $display("FAIL trig_width got=%0d exp=%0d", cyc - t0, TRIG); end
    while (!echo_valid && n < 3 * PER) begin @(negedge clk_50M); n++; any_tx |= tx.tx_valid; end
    t1 = cyc; ev_seen = echo_valid;
    checks++; if (!ev_seen || t1 - t0 != TRIG + TO) begin failures++; $display("FAIL timeout_delay got=%0d exp=%0d", t1 - t0, TRIG + TO); end
    checks++; if (echo_width !== '0) begin failures++; $display("FAIL timeout_width got=%0d exp=0", echo_width); end
    @(negedge clk_50M);
    checks++; if (echo_valid !== 1'b0) begin failures++; $display("FAIL echo_valid_pulse got=%0b exp=0", echo_valid); end
    while (!us_trig && n < 3 * PER) begin @(negedge clk_50M); n++; any_tx |= tx.tx_valid; end
    t2 = cyc;
    checks++; if (t2 - t0 != PER) begin failures++; $display("FAIL trig_period got=%0d exp=%0d", t2 - t0, PER); end
    checks++; if (any_tx || rx.size() != 0) begin failures++; $display("FAIL idle_tx got=%0d exp=0", rx.size()); end
  endtask

  task automatic test_fault_entry;
    bit ok;
    rx.delete(); exp_q.delete(); rdy_mode = 0;
    push_msg(8'h31, 8'h01);
    do_reading(500, 500);
    do_reading(300, 300);
    do_reading(300, 300);
    checks++; if (fault_active !== 1'b0) begin failures++; $display("FAIL entry_early got=%0b exp=0", fault_active); end
    @(negedge clk_50M);
    checks++; if (fault_active !== 1'b1) begin failures++; $display("FAIL entry_fault got=%0b exp=1", fault_active); end
    checks++; if (led_b !== 3'b111 || led_r !== 3'b000 || led_g !== 3'b000) begin
      failures++; $display("FAIL entry_leds got=r%0h g%0h b%0h exp=r0 g0 b7", led_r, led_g, led_b); end
    checks++; if (fault_count !== 4'd1) begin failures++; $display("FAIL entry_count got=%0d exp=1", fault_count); end
    checks++; if (tx.tx_valid !== 1'b0) begin failures++; $display("FAIL entry_tx_early got=%0b exp=0", tx.tx_valid); end
    @(negedge clk_50M);
    checks++; if (tx.tx_valid !== 1'b1 || tx.tx_data !== 8'h46) begin
      failures++; $display("FAIL entry_first_byte got=%0b/%0h exp=1/46", tx.tx_valid, tx.tx_data); end
    wait_rx(MLEN, 100, ok);
    repeat (4) @(negedge clk_50M);
    checks++; if (rx.size() != MLEN || tx.tx_valid !== 1'b0) begin
      failures++; $display("FAIL entry_len got=%0d valid=%0b exp=%0d valid=0", rx.size(), tx.tx_valid, MLEN); end
    for (int i = 0; i < MLEN && i < rx.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL entry_byte%0d got=%0h exp=%0h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_fault_exit;
    do_reading(500, 500);
    @(negedge clk_50M);
    checks++; if (fault_active !== 1'b1) begin failures++; $display("FAIL exit_one_far got=%0b exp=1", fault_active); end
    do_reading(500, 500);
    @(negedge clk_50M);
    checks++; if (fault_active !== 1'b0) begin failures++; $display("FAIL exit_fault got=%0b exp=0", fault_active); end
    checks++; if (led_b !== 3'b111) begin failures++; $display("FAIL exit_leds got=%0h exp=7", led_b); end
  endtask

  task automatic test_no_fault;
    rx.delete();
    do_reading(300, 300);
    do_reading(400, 400);
    @(negedge clk_50M);
    checks++; if (fault_active !== 1'b0) begin failures++; $display("FAIL thresh_far got=%0b exp=0", fault_active); end
    do_reading(399, 399);
    do_reading(1005, 1000);
    @(negedge clk_50M);
    checks++; if (fault_active !== 1'b0 || fault_count !== 4'd1) begin
      failures++; $display("FAIL no_fault got=%0b/%0d exp=0/1", fault_active, fault_count); end
    checks++; if (rx.size() != 0) begin failures++; $display("FAIL no_fault_tx got=%0d exp=0", rx.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    rx.delete(); exp_q.delete();
    push_msg(8'h32, 8'h01); push_msg(8'h34, 8'h01);
    rdy_mode = 1;
    do_reading(300, 300);
    do_reading(300, 300);
    wait_rx(3, 200, ok);
    rdy_mode = 2;
    do_reading(500, 500); do_reading(500, 500); do_reading(300, 300); do_reading(300, 300);
    do_reading(500, 500); do_reading(500, 500); do_reading(300, 300); do_reading(300, 300);
    @(negedge clk_50M);
    checks++; if (fault_count !== 4'd4 || tx.tx_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_stalled got=%0d/%0b exp=4/1", fault_count, tx.tx_valid); end
    rdy_mode = 1;
    wait_rx(MLEN, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_first_msg got=%0d exp=%0d", rx.size(), MLEN); end
    @(negedge clk_50M);
    checks++; if (tx.tx_valid !== 1'b1 || tx.tx_data !== 8'h46) begin
      failures++; $display("FAIL b2b_follow got=%0b/%0h exp=1/46", tx.tx_valid, tx.tx_data); end
    wait_rx(2 * MLEN, 200, ok);
    repeat (6) @(negedge clk_50M);
    checks++; if (rx.size() != 2 * MLEN || tx.tx_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_len got=%0d valid=%0b exp=%0d valid=0", rx.size(), tx.tx_valid, 2 * MLEN); end
    for (int i = 0; i < 2 * MLEN && i < rx.size(); i++) begin
      checks++; if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%0h exp=%0h", i, rx[i], exp_q[i]); end
    end
  endtask

  task automatic test_node_flag;
    node_flag = 1'b1;
    @(negedge clk_50M);
    node_flag = 1'b0;
    checks++; if ({led_r, led_g, led_b} !== '0 || fault_active !== 1'b1) begin
      failures++; $display("FAIL node_clear got=%0h/%0b exp=0/1", {led_r, led_g, led_b}, fault_active); end
    // entry after the clear sets blue again unless node_flag wins on the confirming cycle
    rdy_mode = 2; rx.delete();
    do_reading(500, 500); do_reading(500, 500); do_reading(300, 300);
    do_reading(300, 300);
    node_flag = 1'b1;
    @(negedge clk_50M);
    node_flag = 1'b0;
    checks++; if (fault_active !== 1'b1 || fault_count !== 4'd5) begin
      failures++; $display("FAIL node_entry got=%0b/%0d exp=1/5", fault_active, fault_count); end
    checks++; if (led_b !== 3'b000) begin failures++; $display("FAIL node_priority got=%0h exp=0", led_b); end
    @(negedge clk_50M);
    checks++; if (tx.tx_valid !== 1'b1 || tx.tx_data !== 8'h46) begin
      failures++; $display("FAIL node_report got=%0b/%0h exp=1/46", tx.tx_valid, tx.tx_data); end
  endtask

  task automatic test_reset_mid;
    repeat (3) @(negedge clk_50M);
    rst = 1'b1;
    @(negedge clk_50M);
    checks++; if (tx.tx_valid !== 1'b0 || fault_count !== 4'd0 || fault_active !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%0b/%0d/%0b exp=0/0/0", tx.tx_valid, fault_count, fault_active); end
    rst = 1'b0; rdy_mode = 0;
    repeat (30) @(negedge clk_50M);
    checks++; if (rx.size() != 0 || tx.tx_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset_resend got=%0d exp=0", rx.size()); end
  endtask

  initial begin
    test_reset();
    test_idle_timeout();
    test_fault_entry();
    test_fault_exit();
    test_no_fault();
    test_back_to_back();
    test_node_flag();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
